hpu_axil_regs: RTL and testbench

//  Parametrised AXI4-Lite slave register file for the HPU control plane, clocked by clk.

---
 rtl/hpu_axil_regs.sv | 181 ++++++++++++++++++
 tb/tb_hpu_axil_regs.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_axil_regs.sv
`default_nettype none
// ============================================================================
// hpu_axil_regs : AXI4-Lite register file for the HPU control plane
//   reg0 control (self-clearing), reg1 status, reg2.. parameter words.
// Revision: 1.0
// ============================================================================
module hpu_axil_regs #(
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 8,
    parameter int CTRL_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [31:0]                S_AXI_WDATA,
    input  logic [3:0]                 S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [31:0]                S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    input  logic [31:0]                hw_status,
    input  logic [CTRL_W-1:0]          ctrl_clr,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [32*(NUM_REGS-2)-1:0] param_o,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int NPAR  = NUM_REGS - 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GOT_AW = 3'd1;
    localparam logic [2:0] S_GOT_W  = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_RADDR  = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;

    logic [2:0]          state;
    logic                committed;
    logic [IDX_W-1:0]    aw_idx;
    logic [IDX_W-1:0]    ar_idx;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic [CTRL_W-1:0]   ctrl;
    logic [31:0]         params [NPAR];
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic [31:0]         merged;
    logic [NUM_REGS-1:0] wr_sel;
    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                do_commit;
    logic [3:0]          unused_addr_lsbs;

    assign unused_addr_lsbs = {S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic in_range(input logic [IDX_W-1:0] i);
        return 32'(i) < $unsigned(NUM_REGS);
    endfunction

    function automatic logic [31:0] read_word(input logic [IDX_W-1:0] i);
        logic [31:0] v;
        v = '0;
        if (i == '0)
            v = 32'(ctrl);
        else if (i == IDX_W'(1))
            v = hw_status;
        for (int k = 0; k < NPAR; k++)
            if (i == IDX_W'(k + 2))
                v = params[k];
        return v;
    endfunction

    assign S_AXI_AWREADY = (state == S_IDLE) || (state == S_GOT_W);
    assign S_AXI_WREADY  = (state == S_IDLE) || (state == S_GOT_AW);
    assign S_AXI_ARREADY = (state == S_IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;
    assign S_AXI_BVALID  = (state == S_RESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && !in_range(aw_idx)) ? 2'b10 : 2'b00;
    assign S_AXI_RVALID  = (state == S_RDATA);
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    // The write lands only once, on the edge that ends the first RESP cycle.
    assign do_commit = (state == S_RESP) && !committed;

    always_comb begin
        merged = read_word(aw_idx);
        for (int b = 0; b < 4; b++)
            if (wstrb[b])
                merged[8*b +: 8] = wdata[8*b +: 8];
    end

    // Status word is read-only, and out-of-range indices never match any k.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_REGS; k++)
            wr_sel[k] = (k != 1) && (aw_idx == IDX_W'(k));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            committed <= 1'b0;
            aw_idx    <= '0;
            ar_idx    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            ctrl      <= '0;
            rdata     <= '0;
            rresp     <= 2'b00;
            wr_pulse  <= '0;
            for (int k = 0; k < NPAR; k++)
                params[k] <= '0;
        end else begin
            committed <= (state == S_RESP);
            wr_pulse  <= do_commit ? wr_sel : '0;

            case (state)
                S_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) state <= S_RESP;
                    else if (S_AXI_AWVALID)            state <= S_GOT_AW;
                    else if (S_AXI_WVALID)             state <= S_GOT_W;
                    else if (S_AXI_ARVALID)            state <= S_RADDR;
                end
                S_GOT_AW: if (S_AXI_WVALID)  state <= S_RESP;
                S_GOT_W:  if (S_AXI_AWVALID) state <= S_RESP;
                S_RESP:   if (S_AXI_BREADY)  state <= S_IDLE;
                S_RADDR: begin
                    state <= S_RDATA;
                    rdata <= read_word(ar_idx);
                    rresp <= in_range(ar_idx) ? 2'b00 : 2'b10;
                end
                S_RDATA:  if (S_AXI_RREADY)  state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            if (aw_hs)
                aw_idx <= S_AXI_AWADDR[ADDR_W-1:2];
            if (w_hs) begin
                wdata <= S_AXI_WDATA;
                wstrb <= S_AXI_WSTRB;
            end
            if (ar_hs)
                ar_idx <= S_AXI_ARADDR[ADDR_W-1:2];

            // A bus write to reg0 overrides a hardware clear on the same edge.
            if (do_commit && wr_sel[0])
                ctrl <= merged[CTRL_W-1:0];
            else
                ctrl <= ctrl & ~ctrl_clr;

            for (int k = 0; k < NPAR; k++)
                if (do_commit && wr_sel[k+2])
                    params[k] <= merged;
        end
    end

    assign ctrl_o = ctrl;

    generate
        for (genvar g = 0; g < NPAR; g++) begin : g_param
            assign param_o[32*g +: 32] = params[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hpu_axil_regs.sv
`default_nettype none
// ============================================================================
// tb_hpu_axil_regs : self-checking bench for hpu_axil_regs
// Revision: 1.0
// ============================================================================
module tb_hpu_axil_regs;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [11:0]  awaddr = '0, araddr = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]  wdata = '0, hw_status = '0;
    logic [3:0]   wstrb = '0;
    logic [2:0]   ctrl_clr = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [2:0]   ctrl_o;
    logic [191:0] param_o;
    logic [7:0]   wr_pulse;

    int n_cmp = 0, n_fail = 0;
    logic [31:0] mreg [8];
    int exp_cnt [8];
    int pulse_cnt [8];

    always #5 clk = ~clk;

    hpu_axil_regs dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .hw_status(hw_status), .ctrl_clr(ctrl_clr), .ctrl_o(ctrl_o),
        .param_o(param_o), .wr_pulse(wr_pulse)
    );

    initial for (int k = 0; k < 8; k++) pulse_cnt[k] = 0;
    always @(posedge clk)
        for (int k = 0; k < 8; k++)
            if (wr_pulse[k]) pulse_cnt[k] <= pulse_cnt[k] + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain array of words updated by the register-file rules.
    task automatic model_reset();
        for (int k = 0; k < 8; k++) mreg[k] = '0;
    endtask

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int i;
        i = int'(a[11:2]);
        resp = (i >= 8) ? 2'b10 : 2'b00;
        if (i < 8 && i != 1) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mreg[i][8*b +: 8] = d[8*b +: 8];
            if (i == 0) mreg[0] = mreg[0] & 32'h7;
            exp_cnt[i]++;
        end
    endtask

    task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int i;
        i = int'(a[11:2]);
        resp = (i >= 8) ? 2'b10 : 2'b00;
        d = (i >= 8) ? 32'h0 : (i == 1) ? hw_status : mreg[i];
    endtask

    function automatic logic [191:0] exp_params();
        logic [191:0] v;
        for (int k = 2; k < 8; k++) v[32*(k-2) +: 32] = mreg[k];
        return v;
    endfunction

    task automatic check_regs(input string name);
        check({name, "_ctrl"}, 256'(ctrl_o), 256'(mreg[0][2:0]));
        check({name, "_params"}, 256'(param_o), 256'(exp_params()));
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        int c;
        bit aw_done, w_done, aw_go, w_go;
        c = 0; aw_done = 0; w_done = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && c < 40) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            if (aw_go) aw_done = 1;
            if (w_go)  w_done = 1;
            c++;
        end
        awvalid = 0; wvalid = 0;
        check("wr_handshake", 256'({aw_done, w_done}), 256'(2'b11));
        c = 0;
        while (!bvalid && c < 20) begin @(negedge clk); c++; end
        check("wr_bvalid", 256'(bvalid), 256'(1'b1));
        repeat (b_dly) @(negedge clk);
        resp = bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int c;
        bit done, go;
        c = 0; done = 0;
        araddr = a; arvalid = 1;
        while (!done && c < 40) begin
            go = arready;
            @(negedge clk);
            if (go) done = 1;
            c++;
        end
        arvalid = 0;
        check("rd_handshake", 256'(done), 256'(1'b1));
        c = 0;
        while (!rvalid && c < 20) begin @(negedge clk); c++; end
        check("rd_rvalid", 256'(rvalid), 256'(1'b1));
        d = rdata; resp = rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [1:0]  r, er;
        logic [31:0] d, ed;
        logic [11:0] a;

        vecs[0]  = '{12'h000, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
        vecs[1]  = '{12'h008, 32'h1234_5678, 4'h5, 2'b00, 32'h0034_0078, 2'b00};
        vecs[2]  = '{12'h00C, 32'hAABB_CCDD, 4'h8, 2'b00, 32'hAA00_0000, 2'b00};
        vecs[3]  = '{12'h004, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hCAFE_F00D, 2'b00};
        vecs[4]  = '{12'h020, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[5]  = '{12'h01C, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[6]  = '{12'h000, 32'hFFFF_FFFF, 4'h1, 2'b00, 32'h0000_0007, 2'b00};
        vecs[7]  = '{12'h100, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[8]  = '{12'h00A, 32'h0000_9900, 4'h2, 2'b00, 32'h0034_9978, 2'b00};
        vecs[9]  = '{12'hFFC, 32'h5555_5555, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[10] = '{12'h011, 32'h0BAD_0000, 4'hC, 2'b00, 32'h0BAD_0000, 2'b00};

        for (int k = 0; k < 8; k++) exp_cnt[k] = 0;
        model_reset();

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_readies", 256'({awready, wready, arready}), 256'(3'b111));
        check("rst_valids", 256'({bvalid, rvalid}), 256'(2'b00));
        check("rst_resp_data", 256'({bresp, rresp, rdata}), 256'(0));
        check("rst_pulse", 256'(wr_pulse), 256'(0));
        check_regs("rst");

        // First write: BVALID one cycle after the handshake, commit one cycle later.
        awaddr = 12'h000; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("b_bvalid_rise", 256'(bvalid), 256'(1'b1));
        check("b_ctrl_before", 256'({ctrl_o, wr_pulse}), 256'(0));
        @(negedge clk);
        check("b_ctrl_after", 256'(ctrl_o), 256'(3'b010));
        check("b_pulse", 256'(wr_pulse), 256'(8'h01));
        check("b_bvalid_hold", 256'({bvalid, bresp}), 256'(3'b100));
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("b_pulse_once", 256'({wr_pulse, bvalid}), 256'(0));
        model_write(12'h000, 32'h2, 4'hF, er);

        // AW alone, W three cycles later.
        axi_write(12'h008, 32'h1234_5678, 4'b0101, 0, 3, 0, r);
        model_write(12'h008, 32'h1234_5678, 4'b0101, er);
        check("c_bresp", 256'(r), 256'(2'b00));
        check("c_reg2", 256'(param_o[31:0]), 256'(32'h0034_0078));

        hw_status = 32'hCAFE_F00D;
        for (int v = 0; v < 11; v++) begin
            axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, v % 3, (v + 1) % 3, v % 2, r);
            model_write(vecs[v].addr, vecs[v].data, vecs[v].strb, er);
            check($sformatf("vec%0d_bresp", v), 256'(r), 256'(vecs[v].bresp));
            axi_read(vecs[v].addr, d, r);
            check($sformatf("vec%0d_rdata", v), 256'(d), 256'(vecs[v].rdata));
            check($sformatf("vec%0d_rresp", v), 256'(r), 256'(vecs[v].rresp));
        end
        check_regs("vec_end");

        // Out-of-range read held with RREADY low.
        araddr = 12'h100; arvalid = 1;
        @(negedge clk);
        arvalid = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("d_hold%0d", i), 256'({rvalid, rdata, rresp, arready}), 256'({1'b1, 32'h0, 2'b10, 1'b0}));
            @(negedge clk);
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        check("d_rvalid_drop", 256'(rvalid), 256'(1'b0));

        // Simultaneous AW, W and AR: write first.
        awaddr = 12'h010; wdata = 32'h55; wstrb = 4'hF; araddr = 12'h010;
        awvalid = 1; wvalid = 1; arvalid = 1;
        #1;
        check("e_arready_low", 256'({awready, wready, arready}), 256'(3'b110));
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("e_write_first", 256'({bvalid, rvalid}), 256'(2'b10));
        bready = 1;
        @(negedge clk);
        bready = 0;
        model_write(12'h010, 32'h55, 4'hF, er);
        check("e_arready_after", 256'(arready), 256'(1'b1));
        @(negedge clk);
        arvalid = 0;
        @(negedge clk);
        check("e_read", 256'({rvalid, rdata, rresp}), 256'({1'b1, 32'h55, 2'b00}));
        rready = 1;
        @(negedge clk);
        rready = 0;

        // Control clear coinciding with a reg0 commit, then alone.
        axi_write(12'h000, 32'h3, 4'hF, 0, 0, 0, r);
        model_write(12'h000, 32'h3, 4'hF, er);
        check("f_ctrl_011", 256'(ctrl_o), 256'(3'b011));
        awaddr = 12'h000; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        ctrl_clr = 3'b001;
        @(negedge clk);
        ctrl_clr = 3'b000;
        check("f_commit_wins", 256'(ctrl_o), 256'(3'b101));
        bready = 1;
        @(negedge clk);
        bready = 0;
        model_write(12'h000, 32'h5, 4'hF, er);
        ctrl_clr = 3'b001;
        @(negedge clk);
        ctrl_clr = 3'b000;
        check("f_clr_alone", 256'(ctrl_o), 256'(3'b100));
        mreg[0] = 32'h4;

        // Reset while waiting for write data.
        awaddr = 12'h00C; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("g_got_aw", 256'({awready, wready}), 256'(2'b01));
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        check("g_after_rst", 256'({bvalid, awready, wready, arready}), 256'(4'b0111));
        check_regs("g_rst");
        axi_write(12'h00C, 32'h1122_3344, 4'hF, 0, 0, 0, r);
        model_write(12'h00C, 32'h1122_3344, 4'hF, er);
        check("g_bresp", 256'(r), 256'(er));
        check_regs("g_post");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            a = {10'($urandom_range(0, 11)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wstrb = 4'($urandom_range(0, 15));
                ed = d;
                axi_write(a, ed, wstrb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r);
                model_write(a, ed, wstrb, er);
                check("rnd_bresp", 256'(r), 256'(er));
                check_regs("rnd_wr");
            end else begin
                hw_status = $urandom;
                model_read(a, ed, er);
                axi_read(a, d, r);
                check("rnd_rdata", 256'(d), 256'(ed));
                check("rnd_rresp", 256'(r), 256'(er));
            end
        end

        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++)
            check($sformatf("pulse_count%0d", k), 256'(pulse_cnt[k]), 256'(exp_cnt[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
